opc_decode_pipe: RTL and testbench
==================================

# opc_decode_pipe

Registered, parametrised successor to the ID-stage opcode decoder. It decodes a 32-bit MIPS instruction into one-hot class flags, an ALU operation code, and nop and illegal flags, and latches them in an IF/ID-style output register with stall, flush and valid handling. It also keeps saturating counters for decoded, nop and illegal instructions for pipeline diagnostics. It sits between instruction fetch and the ID/EX register.

## Interface
- CNT_W, 16: width of each performance counter (≥2).
- JAL_EN, 1: 1 decodes opcode 000011 as jal; 0 treats it as illegal.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  inst carries a fetched instruction this cycle.
- inst  in  32  instruction word.
- stall  in  1  hold the output register.
- flush  in  1  squash the output register; has priority over stall.
- cnt_clr  in  1  synchronous clear of all counters.
- out_valid  out  1  registered outputs hold a decoded instruction.
- rt, addi, andi, ori, slti, lw, sw, j, jal, beq, bne  out  1 each  one-hot class flags, registered.
- nop  out  1  instruction word was all zeros.
- illegal  out  1  unknown opcode, or unknown funct for an R-type instruction.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- cnt_inst, cnt_nop, cnt_illegal  out  CNT_W each  saturating event counters.

## Operation
- Combinational decode of opcode inst[31:26]:
  - 000000 rt
  - 001000 addi
  - 001100 andi
  - 001101 ori
  - 001010 slti
  - 100011 lw
  - 101011 sw
  - 000010 j
  - 000011 jal (only when JAL_EN=1)
  - 000100 beq
  - 000101 bne
  - anything else illegal
- nop = (inst == 0). nop overrides decode: every class flag is 0, illegal is 0, alu_op is 000.
- R-type funct inst[5:0]:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct sets illegal=1 and rt=1.
- alu_op for non-R classes:
  - addi, lw, sw: add.
  - andi: and.
  - ori: or.
  - slti: slt.
  - beq, bne: sub.
  - j, jal, illegal opcode: 000.
- Decode outputs are exclusive. At most one class flag is set, except that rt and illegal may both be set.
- Register update, in priority order:
  1. rst: all outputs 0.
  2. flush: out_valid and all decode outputs 0.
  3. stall: hold every output.
  4. Otherwise: out_valid ← in_valid. Decode outputs ← decode(inst) when in_valid=1, and all 0 (a bubble) when in_valid=0.
- An instruction is accepted when in_valid && !stall && !flush && !rst.
- Counters:
  - cnt_inst increments on every accepted instruction.
  - cnt_nop increments on an accepted nop.
  - cnt_illegal increments on an accepted illegal instruction.
  - Each counter saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr zeroes all three counters. Clear beats a same-cycle increment, and that event is not counted.

## Timing
- Reset value of every output is 0, counters included.
- Latency is 1 cycle: inst sampled at edge N appears on the outputs after edge N.
- stall=1 freezes outputs and counters for as long as it is held. On release, the inst presented in that cycle is decoded; stalled inputs are not queued.
- flush and stall together behave as flush; nothing is counted.
- cnt_clr together with an accepted instruction: counters read 0 after the edge, and the output register still loads the instruction.
- Reset asserted mid-stall or mid-flush clears everything on the next edge.
- The counters are the only state besides the output register. There is no multi-cycle FSM.

## Test plan
- Decode sweep, stall=0: inst=0x012A4020 (add), 0x012A4022 (sub), 0x2128_0005 (addi), 0x8D28_0004 (lw), 0x0800_0010 (j), 0x0C00_0010 (jal) → one cycle later the matching flag is set, alu_op is 000/001/000/000/000/000, out_valid=1, and cnt_inst=6 after the sixth edge.
- Illegal and nop: inst=0xFC00_0000 → illegal=1 and all class flags 0. inst=0x0000_003F → rt=1 and illegal=1. inst=0 → nop=1 and rt=0. Afterwards cnt_illegal=2 and cnt_nop=1. Repeat with JAL_EN=0 and inst=0x0C00_0010 → illegal=1.
- Stall/flush: load beq (0x1109_0003), then stall=1 for 3 cycles while inst changes → outputs hold beq with alu_op=001 and the counters stay unchanged. Then flush=1 together with stall=1 → out_valid=0 and all flags 0.
- Bubble: in_valid=0 with stall=0 → out_valid=0, all flags 0, counters unchanged.
- Saturation and clear, CNT_W=2: accept 5 instructions → cnt_inst=3. Then cnt_clr=1 together with an accepted sw → cnt_inst=0 while sw=1 is still registered.
- Reset mid-operation: rst=1 while out_valid=1 with nonzero counters → next edge all outputs and counters are 0, and they stay 0 while rst is held.

Source files
------------

// File: rtl/opc_decode_pipe_if.sv
// Fetch-to-decode bundle: instruction/control inputs, registered decode fields
// and the diagnostic counters.
interface opc_decode_pipe_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      inst;
  logic             stall;
  logic             flush;
  logic             cnt_clr;
  logic             out_valid;
  logic             rt;
  logic             addi;
  logic             andi;
  logic             ori;
  logic             slti;
  logic             lw;
  logic             sw;
  logic             j;
  logic             jal;
  logic             beq;
  logic             bne;
  logic             nop;
  logic             illegal;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] cnt_inst;
  logic [CNT_W-1:0] cnt_nop;
  logic [CNT_W-1:0] cnt_illegal;

  modport master (
    output in_valid, inst, stall, flush, cnt_clr,
    input  out_valid, rt, addi, andi, ori, slti, lw, sw, j, jal, beq, bne,
           nop, illegal, alu_op, cnt_inst, cnt_nop, cnt_illegal
  );

  modport slave (
    input  in_valid, inst, stall, flush, cnt_clr,
    output out_valid, rt, addi, andi, ori, slti, lw, sw, j, jal, beq, bne,
           nop, illegal, alu_op, cnt_inst, cnt_nop, cnt_illegal
  );
endinterface

// File: rtl/opc_decode_pipe.sv
// Registered MIPS opcode decoder with IF/ID-style stall/flush/valid handling
// and saturating decode/nop/illegal counters.
module opc_decode_pipe #(
  parameter int CNT_W  = 16,
  parameter bit JAL_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  opc_decode_pipe_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [5:0]  op_p0;
  logic [5:0]  fn_p0;
  logic [10:0] cls_p0;
  logic        nop_p0;
  logic        ill_p0;
  logic [2:0]  alu_p0;

  assign op_p0 = bus.inst[31:26];
  assign fn_p0 = bus.inst[5:0];

  // Stage p0: combinational decode; cls bits are {rt..bne} in port order
  always_comb begin
    cls_p0 = '0;
    nop_p0 = 1'b0;
    ill_p0 = 1'b0;
    alu_p0 = 3'b000;
    if (bus.inst == 32'd0) begin
      nop_p0 = 1'b1;
    end else begin
      unique case (op_p0)
        6'h00: begin
          cls_p0[10] = 1'b1;
          unique case (fn_p0)
            6'h20:   alu_p0 = 3'b000;
            6'h22:   alu_p0 = 3'b001;
            6'h24:   alu_p0 = 3'b010;
            6'h25:   alu_p0 = 3'b011;
            6'h2A:   alu_p0 = 3'b100;
            default: ill_p0 = 1'b1;
          endcase
        end
        6'h08: cls_p0[9] = 1'b1;
        6'h0C: begin cls_p0[8] = 1'b1; alu_p0 = 3'b010; end
        6'h0D: begin cls_p0[7] = 1'b1; alu_p0 = 3'b011; end
        6'h0A: begin cls_p0[6] = 1'b1; alu_p0 = 3'b100; end
        6'h23: cls_p0[5] = 1'b1;
        6'h2B: cls_p0[4] = 1'b1;
        6'h02: cls_p0[3] = 1'b1;
        6'h03: begin
          if (JAL_EN) cls_p0[2] = 1'b1;
          else        ill_p0    = 1'b1;
        end
        6'h04: begin cls_p0[1] = 1'b1; alu_p0 = 3'b001; end
        6'h05: begin cls_p0[0] = 1'b1; alu_p0 = 3'b001; end
        default: ill_p0 = 1'b1;
      endcase
    end
  end

  logic             vld_p1;
  logic [10:0]      cls_p1;
  logic             nop_p1;
  logic             ill_p1;
  logic [2:0]       alu_p1;
  logic [CNT_W-1:0] cnt_inst_p1;
  logic [CNT_W-1:0] cnt_nop_p1;
  logic [CNT_W-1:0] cnt_ill_p1;
  logic             accept_p0;

  assign accept_p0 = bus.in_valid && !bus.stall && !bus.flush;

  // Stage p1: output register; a non-valid slot loads an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_p1 <= 1'b0;
      cls_p1 <= '0;
      nop_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      alu_p1 <= 3'b000;
    end else if (!bus.stall) begin
      vld_p1 <= bus.in_valid;
      cls_p1 <= bus.in_valid ? cls_p0 : 11'd0;
      nop_p1 <= bus.in_valid & nop_p0;
      ill_p1 <= bus.in_valid & ill_p0;
      alu_p1 <= bus.in_valid ? alu_p0 : 3'b000;
    end
  end

  // Clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      cnt_inst_p1 <= '0;
      cnt_nop_p1  <= '0;
      cnt_ill_p1  <= '0;
    end else if (accept_p0) begin
      cnt_inst_p1 <= sat_inc(cnt_inst_p1);
      if (nop_p0) cnt_nop_p1 <= sat_inc(cnt_nop_p1);
      if (ill_p0) cnt_ill_p1 <= sat_inc(cnt_ill_p1);
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.rt          = cls_p1[10];
  assign bus.addi        = cls_p1[9];
  assign bus.andi        = cls_p1[8];
  assign bus.ori         = cls_p1[7];
  assign bus.slti        = cls_p1[6];
  assign bus.lw          = cls_p1[5];
  assign bus.sw          = cls_p1[4];
  assign bus.j           = cls_p1[3];
  assign bus.jal         = cls_p1[2];
  assign bus.beq         = cls_p1[1];
  assign bus.bne         = cls_p1[0];
  assign bus.nop         = nop_p1;
  assign bus.illegal     = ill_p1;
  assign bus.alu_op      = alu_p1;
  assign bus.cnt_inst    = cnt_inst_p1;
  assign bus.cnt_nop     = cnt_nop_p1;
  assign bus.cnt_illegal = cnt_ill_p1;

endmodule

// File: tb/tb_opc_decode_pipe.sv
// Bench for opc_decode_pipe: two instances (16-bit counters with jal, 2-bit
// counters without jal) driven identically and checked against a table model.
module tb_opc_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, cnt_clr;
  logic [31:0] inst;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  opc_decode_pipe_if #(.CNT_W(16)) b0 ();
  opc_decode_pipe_if #(.CNT_W(2))  b1 ();

  assign b0.in_valid = in_valid; assign b1.in_valid = in_valid;
  assign b0.inst     = inst;     assign b1.inst     = inst;
  assign b0.stall    = stall;    assign b1.stall    = stall;
  assign b0.flush    = flush;    assign b1.flush    = flush;
  assign b0.cnt_clr  = cnt_clr;  assign b1.cnt_clr  = cnt_clr;

  opc_decode_pipe #(.CNT_W(16), .JAL_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  opc_decode_pipe #(.CNT_W(2),  .JAL_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Opcode table in class-flag order rt, addi, andi, ori, slti, lw, sw, j, jal, beq, bne
  localparam logic [5:0] OPC [11] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23,
                                      6'h2B, 6'h02, 6'h03, 6'h04, 6'h05};
  localparam logic [2:0] ALU [11] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd0,
                                      3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
  localparam logic [5:0] FN  [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  typedef struct {
    logic        vld;
    logic [10:0] cls;
    logic        nop;
    logic        ill;
    logic [2:0]  alu;
    int          ci, cn, cl;
  } st_t;

  st_t m [2];

  function automatic st_t ref_decode(input logic [31:0] w, input bit jal_en);
    st_t r;
    int  hit = -1;
    r = '{default: 0};
    r.vld = 1'b1;
    if (w == 32'd0) begin
      r.nop = 1'b1;
      return r;
    end
    for (int i = 0; i < 11; i++)
      if (w[31:26] == OPC[i] && !(i == 8 && !jal_en)) hit = i;
    if (hit < 0) begin
      r.ill = 1'b1;
    end else begin
      r.cls[10-hit] = 1'b1;
      r.alu = ALU[hit];
      if (hit == 0) begin
        r.ill = 1'b1;
        for (int f = 0; f < 5; f++)
          if (w[5:0] == FN[f]) begin r.ill = 1'b0; r.alu = 3'(f); end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int   mx;
      st_t  d;
      mx = (k == 0) ? 65535 : 3;
      if (rst) begin
        m[k] = '{default: 0};
      end else begin
        d = ref_decode(inst, k == 0);
        if (cnt_clr) begin
          m[k].ci = 0; m[k].cn = 0; m[k].cl = 0;
        end else if (in_valid && !stall && !flush) begin
          if (m[k].ci < mx) m[k].ci++;
          if (d.nop && m[k].cn < mx) m[k].cn++;
          if (d.ill && m[k].cl < mx) m[k].cl++;
        end
        if (flush) begin
          m[k].vld = 0; m[k].cls = 0; m[k].nop = 0; m[k].ill = 0; m[k].alu = 0;
        end else if (!stall) begin
          if (in_valid) begin
            m[k].vld = 1; m[k].cls = d.cls; m[k].nop = d.nop; m[k].ill = d.ill; m[k].alu = d.alu;
          end else begin
            m[k].vld = 0; m[k].cls = 0; m[k].nop = 0; m[k].ill = 0; m[k].alu = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t dut_state(input int k);
    st_t s;
    s = '{default: 0};
    if (k == 0) begin
      s.vld = b0.out_valid; s.nop = b0.nop; s.ill = b0.illegal; s.alu = b0.alu_op;
      s.cls = {b0.rt, b0.addi, b0.andi, b0.ori, b0.slti, b0.lw, b0.sw, b0.j, b0.jal, b0.beq, b0.bne};
      s.ci = int'(b0.cnt_inst); s.cn = int'(b0.cnt_nop); s.cl = int'(b0.cnt_illegal);
    end else begin
      s.vld = b1.out_valid; s.nop = b1.nop; s.ill = b1.illegal; s.alu = b1.alu_op;
      s.cls = {b1.rt, b1.addi, b1.andi, b1.ori, b1.slti, b1.lw, b1.sw, b1.j, b1.jal, b1.beq, b1.bne};
      s.ci = int'(b1.cnt_inst); s.cn = int'(b1.cnt_nop); s.cl = int'(b1.cnt_illegal);
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        st_t s;
        s = dut_state(k);
        chk($sformatf("dut%0d out_valid", k), s.vld, m[k].vld);
        chk($sformatf("dut%0d class", k),     s.cls, m[k].cls);
        chk($sformatf("dut%0d nop", k),       s.nop, m[k].nop);
        chk($sformatf("dut%0d illegal", k),   s.ill, m[k].ill);
        chk($sformatf("dut%0d alu_op", k),    s.alu, m[k].alu);
        chk($sformatf("dut%0d cnt_inst", k),  s.ci,  m[k].ci);
        chk($sformatf("dut%0d cnt_nop", k),   s.cn,  m[k].cn);
        chk($sformatf("dut%0d cnt_ill", k),   s.cl,  m[k].cl);
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] w, input logic s,
                     input logic f, input logic c, input logic r);
    in_valid = v; inst = w; stall = s; flush = f; cnt_clr = c; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int          sel;
    in_valid = 0; inst = 0; stall = 0; flush = 0; cnt_clr = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset out_valid", b0.out_valid, 0);
    chk("reset cnt_inst",  b0.cnt_inst, 0);

    cyc(1, 32'h012A4020, 0, 0, 0, 0);
    chk("add rt", b0.rt, 1); chk("add alu", b0.alu_op, 3'b000); chk("add vld", b0.out_valid, 1);
    cyc(1, 32'h012A4022, 0, 0, 0, 0);
    chk("sub alu", b0.alu_op, 3'b001);
    cyc(1, 32'h21280005, 0, 0, 0, 0);
    chk("addi flag", b0.addi, 1);
    cyc(1, 32'h8D280004, 0, 0, 0, 0);
    chk("lw flag", b0.lw, 1);
    cyc(1, 32'h08000010, 0, 0, 0, 0);
    chk("j flag", b0.j, 1);
    cyc(1, 32'h0C000010, 0, 0, 0, 0);
    chk("jal flag", b0.jal, 1);
    chk("jal disabled illegal", b1.illegal, 1);
    chk("cnt_inst six", b0.cnt_inst, 6);
    chk("cnt_inst saturated", b1.cnt_inst, 3);

    cyc(1, 32'hFC000000, 0, 0, 0, 0);
    chk("bad opcode illegal", b0.illegal, 1);
    cyc(1, 32'h0000003F, 0, 0, 0, 0);
    chk("bad funct rt", b0.rt, 1); chk("bad funct illegal", b0.illegal, 1);
    cyc(1, 32'h00000000, 0, 0, 0, 0);
    chk("nop flag", b0.nop, 1); chk("nop rt", b0.rt, 0);
    chk("cnt_illegal two", b0.cnt_illegal, 2); chk("cnt_nop one", b0.cnt_nop, 1);

    cyc(1, 32'h11090003, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, $urandom, 1, 0, 0, 0);
      chk("stall beq", b0.beq, 1); chk("stall alu", b0.alu_op, 3'b001);
      chk("stall cnt", b0.cnt_inst, 10);
    end
    cyc(1, 32'h012A4020, 1, 1, 0, 0);
    chk("flush vld", b0.out_valid, 0); chk("flush beq", b0.beq, 0); chk("flush cnt", b0.cnt_inst, 10);
    cyc(0, 32'h012A4020, 0, 0, 0, 0);
    chk("bubble vld", b0.out_valid, 0); chk("bubble rt", b0.rt, 0); chk("bubble cnt", b0.cnt_inst, 10);

    cyc(1, 32'hAD280004, 0, 0, 1, 0);
    chk("clr cnt16", b0.cnt_inst, 0); chk("clr cnt2", b1.cnt_inst, 0); chk("clr sw", b1.sw, 1);

    cyc(1, 32'h00000000, 0, 0, 0, 0);
    cyc(1, 32'hFC000000, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h012A4020, 0, 0, 0, 1);
      chk("rst vld", b0.out_valid, 0); chk("rst cnt", b0.cnt_inst, 0);
      chk("rst cnt_nop", b1.cnt_nop, 0);
    end

    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      sel = $urandom_range(5);
      if (sel == 0) w = 32'd0;
      else if (sel == 1) begin
        w[31:26] = 6'h00;
        if ($urandom_range(3) != 0) w[5:0] = FN[$urandom_range(4)];
      end else if (sel <= 3) w[31:26] = OPC[$urandom_range(10)];
      cyc($urandom_range(3) != 0, w, $urandom_range(4) == 0, $urandom_range(19) == 0,
          $urandom_range(49) == 0, $urandom_range(99) == 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
